golay_encoder: RTL and testbench
================================

# golay_encoder

Bit-serial systematic encoder for the extended Golay (24,12) code. It is the transmit-side stage directly upstream of the syndrome/RAM decoder. It takes a 12-bit data word and produces the 24-bit codeword {data, parity}, whose syndrome under the decoder's check equations is zero. Parity is accumulated one data bit per cycle, and the result is delivered with the same ready/enable/finish handshake the decoder uses.

## Interface
- No parameters. Code tables are fixed constants.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  request to encode `input_vector`. Sampled only when `ready`=1.
- input_vector  in  12  data word d[11:0]. Maps to codeword bits [23:12], so d[11] is c23.
- output_vector  out  24  registered codeword {d, p[11:0]}.
- ready  out  1  block is idle and will accept `enable`.
- finish  out  1  one-cycle pulse: `output_vector` has just been updated.

## Operation
- Parity definition: p[i] = XOR-reduce(d & M[i]).
  - M[11:0] = FFE, A3B, D1D, 68F, B47, DA3, ED1, 769, 3B5, 1DB, 8ED, 477 (hex, listed from M[11] down to M[0]).
  - Mask bit k selects d[k], which is codeword bit c(12+k).
- Bit-serial form: COL[k] = {M[11][k], …, M[0][k]}. Processing d[k] XORs COL[k] into the 12-bit parity accumulator when d[k]=1. The result must equal the parallel definition for all 4096 inputs.
- States:
  - IDLE:
    - ready=1.
    - On enable=1: latch input_vector into the data register, clear the accumulator, set the bit counter to 11, set ready←0, go to CALC.
  - CALC:
    - Each cycle, process d[cnt], then decrement cnt.
    - After d[0] is processed (12 cycles), go to DONE.
    - ready=0. `enable` is ignored and the data register is not reloaded.
  - DONE:
    - output_vector←{d, acc}, finish←1, ready←1, go to IDLE.
- finish is cleared on the next edge, so it is high for exactly one cycle.
- output_vector holds the last codeword until the next DONE. It is never updated mid-calculation.
- Changes to input_vector after acceptance have no effect on the word in flight.
- Counter is 4 bits; valid values are 11..0. It never wraps below 0: the CALC→DONE transition occurs at cnt=0.
- Unused state encodings return to IDLE on the next edge, with no finish pulse.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - state=IDLE, ready=1, finish=0, output_vector=0;
  - accumulator=0, counter=0, data register=0.
- Reset has priority over all other activity, including mid-CALC and in DONE. The word in flight is discarded and no finish pulse occurs.
- Let E0 be the acceptance edge (enable=1 and ready=1).
  - CALC runs on edges E1..E12.
  - At E13: output_vector is valid, finish=1, ready=1.
  - At E14: finish=0.
- Latency is 13 cycles from acceptance to finish.
- The next word can be accepted at E14 if enable is held high. Maximum throughput is one word per 14 cycles.
- If enable=1 on the same edge as the DONE→IDLE transition (E13), it is not accepted, because acceptance requires ready=1 in the current state.
- enable held continuously high encodes repeatedly, sampling input_vector on each acceptance edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with enable=1 → ready=1, finish=0, output_vector=0x000000, no acceptance.
- Known vectors, each followed by finish exactly 13 cycles after acceptance:
  - 0x000 → 0x000000
  - 0x001 → 0x0017FF
  - 0x800 → 0x800EE2
  - 0xFFF → 0xFFFFFF
- Exhaustive check: all 4096 inputs, back-to-back with enable held high. Each output must have zero syndrome under the decoder's 12 check equations, output_vector[23:12] must equal the input, and acceptances must be spaced 14 cycles apart.
- Busy protection: accept 0x800, then drive enable=1 with input_vector=0x001 during CALC → result is 0x800EE2, with exactly one finish pulse.
- Reset mid-operation: accept 0xFFF, assert rst_n=0 at E6 → no finish, output_vector=0, and ready=1 on the next cycle. A subsequent encode of 0x001 yields 0x0017FF.
- Loopback: feed encoder output, with a single-bit error XORed in at each of the 24 positions, into the decoder → the decoder's output_vector equals the original data.

Source files
------------

// File: rtl/golay_encoder.sv
// Bit-serial systematic encoder for the extended Golay (24,12) code.
// Produces {data, parity}; one data bit is folded into the parity per cycle.
module golay_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] input_vector,
    output logic [23:0] output_vector,
    output logic        ready,
    output logic        finish
);

    // Parity masks, M[11] first; column k of this table is the parity
    // contribution of data bit d[k].
    localparam logic [11:0][11:0] C_M = {
        12'hFFE, 12'hA3B, 12'hD1D, 12'h68F, 12'hB47, 12'hDA3,
        12'hED1, 12'h769, 12'h3B5, 12'h1DB, 12'h8ED, 12'h477
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_data;
    logic [11:0] r_acc;
    logic [3:0]  r_cnt;

    logic [11:0] w_col;
    logic        w_bit;

    always_comb begin
        w_col = '0;
        for (int i = 0; i < 12; i++) begin
            w_col[i] = C_M[i][r_cnt];
        end
        w_bit = r_data[r_cnt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_data        <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
            output_vector <= '0;
            ready         <= 1'b1;
            finish        <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && ready) begin
                        r_data  <= input_vector;
                        r_acc   <= '0;
                        r_cnt   <= 4'd11;
                        ready   <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_bit) begin
                        r_acc <= r_acc ^ w_col;
                    end
                    // Counter parks at 0; the exit is taken on the last bit.
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    output_vector <= {r_data, r_acc};
                    finish        <= 1'b1;
                    ready         <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_golay_encoder.sv
// Directed self-checking bench for golay_encoder, with a parallel parity
// model and a single-error-correcting reference decoder for loopback.
`timescale 1ns/1ps
module tb_golay_encoder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [11:0] input_vector;
    logic [23:0] output_vector;
    logic        ready;
    logic        finish;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0][11:0] M = {
        12'hFFE, 12'hA3B, 12'hD1D, 12'h68F, 12'hB47, 12'hDA3,
        12'hED1, 12'h769, 12'h3B5, 12'h1DB, 12'h8ED, 12'h477
    };

    golay_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .input_vector (input_vector),
        .output_vector(output_vector),
        .ready        (ready),
        .finish       (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] syndrome(input logic [23:0] cw);
        logic [11:0] s;
        for (int i = 0; i < 12; i++) begin
            s[i] = (^(cw[23:12] & M[i])) ^ cw[i];
        end
        return s;
    endfunction

    // Reference single-error decoder: match syndrome against the 24
    // single-bit error signatures.
    function automatic logic [11:0] decode(input logic [23:0] cw);
        logic [11:0] s;
        logic [11:0] col;
        logic [23:0] fixed;
        s = syndrome(cw);
        fixed = cw;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 12; i++) col[i] = M[i][k];
            if (s == col) fixed[12+k] = ~cw[12+k];
            if (s == (12'h001 << k)) fixed[k] = ~cw[k];
        end
        return fixed[23:12];
    endfunction

    // Accepts v on the next edge (caller ensures ready=1), returns cycles to finish or -1.
    task automatic encode(input logic [11:0] v, output int lat);
        input_vector = v;
        enable = 1'b1;
        step();
        enable = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (finish) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        input_vector = 12'hABC;
        repeat (3) step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
        checks++; if (output_vector !== 24'h0) begin errors++; $display("FAIL reset_out got=%h exp=000000", output_vector); end
        enable = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_no_accept got=%b exp=1", ready); end
    endtask

    task automatic test_known();
        logic [11:0] din [4] = '{12'h000, 12'h001, 12'h800, 12'hFFF};
        logic [23:0] exp [4] = '{24'h000000, 24'h0017FF, 24'h800EE2, 24'hFFFFFF};
        int lat;
        for (int t = 0; t < 4; t++) begin
            encode(din[t], lat);
            checks++; if (lat != 13) begin errors++; $display("FAIL known_latency[%0d] got=%0d exp=13", t, lat); end
            checks++; if (output_vector !== exp[t]) begin errors++; $display("FAIL known_out[%0d] got=%h exp=%h", t, output_vector, exp[t]); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL known_ready[%0d] got=%b exp=1", t, ready); end
            step();
            checks++; if (finish !== 1'b0) begin errors++; $display("FAIL known_finish_clr[%0d] got=%b exp=0", t, finish); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] q[$];
        logic [11:0] d;
        logic        rdy;
        int cyc = 0, done = 0, next = 0, last_acc = -1;
        input_vector = 12'h000;
        enable = 1'b1;
        while (done < 4096 && cyc < 4096 * 14 + 200) begin
            rdy = ready;
            step();
            cyc++;
            if (rdy && next < 4096) begin
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 14) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=14", next, cyc - last_acc); end
                end
                last_acc = cyc;
                q.push_back(next[11:0]);
                next++;
                input_vector = next[11:0];
            end
            if (finish) begin
                d = (q.size() > 0) ? q.pop_front() : 12'h000;
                checks++; if (output_vector[23:12] !== d) begin errors++; $display("FAIL b2b_data got=%h exp=%h", output_vector[23:12], d); end
                checks++; if (syndrome(output_vector) !== 12'h000) begin errors++; $display("FAIL b2b_syndrome[%h] got=%h exp=000", d, syndrome(output_vector)); end
                done++;
            end
        end
        enable = 1'b0;
        checks++; if (done != 4096) begin errors++; $display("FAIL b2b_count got=%0d exp=4096", done); end
        step();
    endtask

    task automatic test_busy();
        int pulses = 0;
        int lat = -1;
        input_vector = 12'h800;
        enable = 1'b1;
        step();
        input_vector = 12'h001;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (finish) begin
                pulses++;
                lat = n;
                break;
            end
        end
        enable = 1'b0;
        checks++; if (lat != 13) begin errors++; $display("FAIL busy_latency got=%0d exp=13", lat); end
        checks++; if (output_vector !== 24'h800EE2) begin errors++; $display("FAIL busy_out got=%h exp=800EE2", output_vector); end
        repeat (16) begin
            step();
            if (finish) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_idle got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int lat;
        input_vector = 12'hFFF;
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (5) begin
            step();
            if (finish) pulses++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        checks++; if (output_vector !== 24'h0) begin errors++; $display("FAIL rstmid_out got=%h exp=000000", output_vector); end
        repeat (12) begin
            step();
            if (finish) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
        encode(12'h001, lat);
        checks++; if (lat != 13) begin errors++; $display("FAIL rstmid_latency got=%0d exp=13", lat); end
        checks++; if (output_vector !== 24'h0017FF) begin errors++; $display("FAIL rstmid_out2 got=%h exp=0017FF", output_vector); end
        step();
    endtask

    task automatic test_loopback();
        logic [11:0] din [4] = '{12'h001, 12'h800, 12'hA5C, 12'h3F0};
        logic [23:0] cw;
        logic [11:0] got;
        int lat;
        for (int t = 0; t < 4; t++) begin
            encode(din[t], lat);
            cw = output_vector;
            step();
            for (int p = 0; p < 24; p++) begin
                got = decode(cw ^ (24'h1 << p));
                checks++; if (got !== din[t]) begin errors++; $display("FAIL loopback[%h bit%0d] got=%h exp=%h", din[t], p, got, din[t]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        input_vector = 12'h000;
        test_reset();
        test_known();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
